commit_stage: RTL and testbench
===============================

Name: commit_stage

Overview:
- Retirement stage directly downstream of the single-cycle RV64 datapath, one instruction per clock.
- Registers each cycle's retiring instruction (pc, inst, register write) into a one-cycle-late commit record for the difftest InstrCommit port.
- Keeps the cycle and instruction counters and detects the trap instruction (opcode 7'h6b), then halts commit reporting.
- Replaces the ad-hoc commit registers at the top level with a self-contained block.

Parameters:
- PC_START, 64'h0000_0000_8000_0000, reset PC; the first commit at this address is flagged skip.
- TRAP_OPCODE, 7'h6b, inst[6:0] value that ends simulation.
- XLEN, 64, datapath and counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  datapath retires an instruction this cycle.
- in_pc  in  XLEN  PC of the retiring instruction.
- in_inst  in  32  instruction word.
- in_wen  in  1  register-file write enable.
- in_wdest  in  5  destination register.
- in_wdata  in  XLEN  write-back data.
- in_a0  in  XLEN  current value of x10; provides the trap code.
- cmt_valid  out  1  commit record valid.
- cmt_pc  out  XLEN  committed PC.
- cmt_inst  out  32  committed instruction.
- cmt_wen  out  1  committed write enable, forced 0 when wdest==0.
- cmt_wdest  out  8  {3'b0, wdest}.
- cmt_wdata  out  XLEN  committed write data.
- cmt_skip  out  1  difftest must skip this commit.
- trap_valid  out  1  one-cycle pulse: trap retired.
- trap_code  out  8  in_a0[7:0] sampled at the trap.
- trap_pc  out  XLEN  PC of the trap instruction.
- cycle_cnt  out  XLEN  cycles spent in RUN.
- instr_cnt  out  XLEN  instructions committed.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async assert, sync release): state=RUN, first_done=0; every output 0.
- FSM states: RUN, TRAP, HALT.
  - RUN -> TRAP when in_valid && in_inst[6:0]==TRAP_OPCODE.
  - TRAP -> HALT unconditionally after one cycle.
  - HALT is held until reset.
- RUN, each clock edge:
  - cycle_cnt += 1.
  - If in_valid: register pc/inst/wen/wdest/wdata into cmt_*, cmt_valid=1, instr_cnt += 1.
  - If !in_valid: cmt_valid=0; other cmt_* fields hold.
- Latency: cmt_* appear exactly 1 cycle after the input cycle.
- cmt_wen = in_wen && (in_wdest != 0); cmt_wdest zero-extended to 8 bits.
- cmt_skip=1 only for the first valid commit after reset, and only if in_pc==PC_START.
  - first_done sets on the first valid commit whether or not it skipped.
  - Later commits to PC_START (e.g. jump back) are not skipped.
- Trap commit (RUN edge with the trap instruction):
  - Handled as a normal commit, so cmt_valid=1 and instr_cnt includes the trap.
  - trap_code and trap_pc are latched.
  - trap_valid=1 in the following cycle (state TRAP), aligned with that cmt_valid.
- TRAP edge: trap_valid=0, cmt_valid=0, halted=1; counters frozen.
- HALT: inputs ignored; cmt_valid=0; counters, trap_code and trap_pc hold.
- Counters wrap modulo 2^XLEN with no saturation.
- Reset mid-operation (any state): everything returns to reset values immediately, with no clock required; first_done clears.
- in_valid with unknown inst during RUN: only the opcode compare is required to be defined.

Test Plan:
- Reset at 0x80000000 ->
  - first commit (pc=0x80000000, addi x1) gives cmt_valid=1, cmt_skip=1 one cycle later.
  - Second commit (pc=0x80000004) gives cmt_skip=0.
  - instr_cnt=2, cycle_cnt=2.
- Commit with wen=1, wdest=0, wdata=0xdead -> cmt_wen=0, cmt_wdest=8'h00, cmt_wdata=0xdead.
- Bubble (in_valid=0) for 3 cycles between two commits -> cmt_valid low 3 cycles; cycle_cnt +5 over the 5 edges; instr_cnt +2.
- Trap inst 0x0000006b at pc=0x80000010, a0=0 after 4 prior commits ->
  - trap_valid pulses once with code 0x00, pc 0x80000010, aligned with that commit.
  - instr_cnt=5; halted=1 next cycle.
  - Further in_valid produces no cmt_valid, and counters freeze.
- Trap with a0=1 -> trap_code=0x01 (bad trap); halted asserted.
- reset_n pulsed low mid-clock while in HALT -> outputs clear asynchronously; after release, the next commit at PC_START is skipped again.

Source files
------------

// File: rtl/commit_stage.sv
// commit_stage: retirement stage for the single-cycle RV64 datapath.
// Turns each retiring instruction into a one-cycle-late commit record,
// counts cycles and retired instructions, and stops reporting once the
// trap instruction has retired.
module commit_stage #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] PC_START    = 64'h0000_0000_8000_0000,
  parameter logic [6:0]      TRAP_OPCODE = 7'h6b
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_wen,
  input  logic [4:0]      in_wdest,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0] in_a0,
  output logic            cmt_valid,
  output logic [XLEN-1:0] cmt_pc,
  output logic [31:0]     cmt_inst,
  output logic            cmt_wen,
  output logic [7:0]      cmt_wdest,
  output logic [XLEN-1:0] cmt_wdata,
  output logic            cmt_skip,
  output logic            trap_valid,
  output logic [7:0]      trap_code,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instr_cnt,
  output logic            halted
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  logic   first_done;
  logic   is_trap;
  logic   unused_a0_high;

  // Only the low byte of a0 carries the trap code.
  assign unused_a0_high = ^in_a0[XLEN-1:8];

  // The opcode compare is the only decode this stage does.
  assign is_trap = in_valid && (in_inst[6:0] == TRAP_OPCODE);

  // Commit record, counters, trap latch and RUN/TRAP/HALT sequencing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      first_done <= 1'b0;
      cmt_valid  <= 1'b0;
      cmt_pc     <= '0;
      cmt_inst   <= '0;
      cmt_wen    <= 1'b0;
      cmt_wdest  <= '0;
      cmt_wdata  <= '0;
      cmt_skip   <= 1'b0;
      trap_valid <= 1'b0;
      trap_code  <= '0;
      trap_pc    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cycle_cnt  <= cycle_cnt + XLEN'(1);
          trap_valid <= 1'b0;
          cmt_valid  <= in_valid;
          if (in_valid) begin
            cmt_pc     <= in_pc;
            cmt_inst   <= in_inst;
            cmt_wen    <= in_wen && (in_wdest != 5'd0);
            cmt_wdest  <= {3'b000, in_wdest};
            cmt_wdata  <= in_wdata;
            cmt_skip   <= !first_done && (in_pc == PC_START);
            first_done <= 1'b1;
            instr_cnt  <= instr_cnt + XLEN'(1);
          end
          if (is_trap) begin
            trap_valid <= 1'b1;
            trap_code  <= in_a0[7:0];
            trap_pc    <= in_pc;
            state      <= TRAP;
          end
        end
        TRAP: begin
          trap_valid <= 1'b0;
          cmt_valid  <= 1'b0;
          halted     <= 1'b1;
          state      <= HALT;
        end
        HALT: begin
          cmt_valid  <= 1'b0;
          trap_valid <= 1'b0;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: scoreboard bench for commit_stage.
// The driver predicts each commit record and pushes it into a queue; a
// negedge monitor pops and compares whenever the DUT shows cmt_valid.
module tb_commit_stage;

  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        in_wen;
  logic [4:0]  in_wdest;
  logic [63:0] in_wdata;
  logic [63:0] in_a0;
  logic        cmt_valid;
  logic [63:0] cmt_pc;
  logic [31:0] cmt_inst;
  logic        cmt_wen;
  logic [7:0]  cmt_wdest;
  logic [63:0] cmt_wdata;
  logic        cmt_skip;
  logic        trap_valid;
  logic [7:0]  trap_code;
  logic [63:0] trap_pc;
  logic [63:0] cycle_cnt;
  logic [63:0] instr_cnt;
  logic        halted;

  commit_stage dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata), .in_a0(in_a0),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
    .cmt_wen(cmt_wen), .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata),
    .cmt_skip(cmt_skip), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
    .halted(halted)
  );

  // 10-unit clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        skip;
    logic        trap;
    logic [7:0]  code;
    logic [63:0] cyc;
    logic [63:0] icnt;
  } rec_t;

  rec_t expQ[$];

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = reporting, 1 = trap just retired, 2 = halted.
  int          m_phase;
  bit          m_first;
  bit          m_exp_valid;
  bit          m_trapped;
  logic [63:0] m_cyc;
  logic [63:0] m_icnt;
  logic [7:0]  m_code;
  logic [63:0] m_tpc;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, predicts its effect, and waits past the capturing edge.
  task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                               input logic wen, input logic [4:0] wd,
                               input logic [63:0] wdata, input logic [63:0] a0);
    rec_t r;
    in_valid = v; in_pc = pc; in_inst = inst; in_wen = wen;
    in_wdest = wd; in_wdata = wdata; in_a0 = a0;
    m_exp_valid = 1'b0;
    if (m_phase == 0) begin
      m_cyc = m_cyc + 1;
      if (v) begin
        m_icnt   = m_icnt + 1;
        r.pc     = pc;
        r.inst   = inst;
        r.wen    = wen && (wd != 0);
        r.wdest  = {3'b000, wd};
        r.wdata  = wdata;
        r.skip   = !m_first && (pc == PC_START);
        r.trap   = (inst[6:0] == 7'h6b);
        r.code   = a0[7:0];
        r.cyc    = m_cyc;
        r.icnt   = m_icnt;
        m_first  = 1'b1;
        m_exp_valid = 1'b1;
        if (r.trap) begin
          m_phase   = 1;
          m_trapped = 1'b1;
          m_code    = a0[7:0];
          m_tpc     = pc;
        end
        expQ.push_back(r);
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end
    @(posedge clock);
    #1;
  endtask

  // Compares the externally visible state against the model right after an edge.
  task automatic checkOutput(input string tag);
    checkVal({tag, ".cycle_cnt"}, cycle_cnt, m_cyc);
    checkVal({tag, ".instr_cnt"}, instr_cnt, m_icnt);
    checkVal({tag, ".halted"}, 64'(halted), 64'(m_phase == 2));
    checkVal({tag, ".cmt_valid"}, 64'(cmt_valid), 64'(m_exp_valid));
    if (m_trapped) begin
      checkVal({tag, ".trap_code"}, 64'(trap_code), 64'(m_code));
      checkVal({tag, ".trap_pc"}, trap_pc, m_tpc);
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after an edge.
  task automatic doReset();
    in_valid = 1'b0;
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkVal("rst.cmt_valid", 64'(cmt_valid), 64'd0);
    checkVal("rst.cmt_pc", cmt_pc, 64'd0);
    checkVal("rst.cmt_skip", 64'(cmt_skip), 64'd0);
    checkVal("rst.trap_valid", 64'(trap_valid), 64'd0);
    checkVal("rst.trap_code", 64'(trap_code), 64'd0);
    checkVal("rst.cycle_cnt", cycle_cnt, 64'd0);
    checkVal("rst.instr_cnt", instr_cnt, 64'd0);
    checkVal("rst.halted", 64'(halted), 64'd0);
    checkVal("rst.queue_empty", 64'(expQ.size()), 64'd0);
    expQ.delete();
    m_phase = 0; m_first = 1'b0; m_exp_valid = 1'b0; m_trapped = 1'b0;
    m_cyc = '0; m_icnt = '0; m_code = '0; m_tpc = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: every presented commit must match the oldest prediction.
  always @(negedge clock) begin
    rec_t r;
    if (reset_n === 1'b1) begin
      if (cmt_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_commit: got pc %0h expected no commit", cmt_pc);
        end else begin
          r = expQ.pop_front();
          checkVal("mon.pc", cmt_pc, r.pc);
          checkVal("mon.inst", 64'(cmt_inst), 64'(r.inst));
          checkVal("mon.wen", 64'(cmt_wen), 64'(r.wen));
          checkVal("mon.wdest", 64'(cmt_wdest), 64'(r.wdest));
          checkVal("mon.wdata", cmt_wdata, r.wdata);
          checkVal("mon.skip", 64'(cmt_skip), 64'(r.skip));
          checkVal("mon.trap_valid", 64'(trap_valid), 64'(r.trap));
          checkVal("mon.cycle_cnt", cycle_cnt, r.cyc);
          checkVal("mon.instr_cnt", instr_cnt, r.icnt);
          if (r.trap) begin
            checkVal("mon.trap_code", 64'(trap_code), 64'(r.code));
            checkVal("mon.trap_pc", trap_pc, r.pc);
          end
        end
      end else if (trap_valid === 1'b1) begin
        checks++; errors++;
        $display("[TB] FAIL trap_without_commit: got trap_valid 1 expected 0");
      end
    end
  end

  initial begin
    logic [31:0] inst;
    logic [63:0] pc;
    reset_n = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_inst = '0; in_wen = 1'b0;
    in_wdest = '0; in_wdata = '0; in_a0 = '0;
    expQ.delete();
    #3;
    doReset();

    // First commit at PC_START is skipped, the second is not.
    applyStimulus(1, PC_START, 32'h0010_0093, 1, 5'd1, 64'd1, 64'd0);
    applyStimulus(1, PC_START + 4, 32'h0020_0113, 1, 5'd2, 64'd2, 64'd0);
    checkOutput("two_commits");
    // Write to x0 is reported with wen forced low.
    applyStimulus(1, PC_START + 8, 32'h0de0_0013, 1, 5'd0, 64'hdead, 64'd0);
    applyStimulus(1, PC_START + 12, 32'h0000_0013, 0, 5'd3, 64'd7, 64'd0);
    // Good trap after four commits, then further input is ignored.
    applyStimulus(1, PC_START + 16, 32'h0000_006b, 0, 5'd0, 64'd0, 64'd0);
    checkOutput("trap_edge");
    applyStimulus(1, PC_START + 20, 32'h0000_0013, 1, 5'd4, 64'd9, 64'd0);
    checkOutput("trap_to_halt");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, PC_START + 24, 32'h0000_0013, 1, 5'd5, 64'd9, 64'd0);
    checkOutput("halt_frozen");

    // Reset while halted; PC_START is skipped again, bubbles, jump back, bad trap.
    doReset();
    applyStimulus(1, PC_START, 32'h0010_0093, 1, 5'd1, 64'd1, 64'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 64'd0, 32'd0, 0, 5'd0, 64'd0, 64'd0);
    checkOutput("bubbles");
    applyStimulus(1, PC_START + 4, 32'h0020_0113, 1, 5'd2, 64'd2, 64'd0);
    checkOutput("after_bubbles");
    applyStimulus(1, PC_START, 32'h0010_0093, 1, 5'd1, 64'd3, 64'd0);
    applyStimulus(1, PC_START + 4, 32'h0000_006b, 0, 5'd0, 64'd0, 64'd1);
    applyStimulus(0, 64'd0, 32'd0, 0, 5'd0, 64'd0, 64'd0);
    applyStimulus(0, 64'd0, 32'd0, 0, 5'd0, 64'd0, 64'd0);
    checkOutput("bad_trap");

    // Randomized rounds, each started from reset.
    for (int round = 0; round < 4; round++) begin
      doReset();
      for (int n = 0; n < 150; n++) begin
        inst = $urandom;
        if ($urandom_range(63, 0) == 0) inst[6:0] = 7'h6b;
        else if (inst[6:0] == 7'h6b) inst[0] = ~inst[0];
        pc = {32'h0, $urandom} & ~64'd3;
        if ($urandom_range(3, 0) == 0) pc = PC_START;
        applyStimulus(1'($urandom_range(3, 0) != 0), pc, inst, 1'($urandom),
                      5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        if (n % 25 == 24) checkOutput("random");
      end
      checkOutput("random_end");
    end

    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkVal("final.queue_empty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
